dmac_read_req_gen: RTL and testbench
====================================

Name: dmac_read_req_gen

Overview:
Read-side counterpart of the DMA write request generator. Accepts one transfer command per channel slot: source address, beat count, burst type and size. Splits it into AXI4 read-address requests that respect MAX_BURST_LEN and the AXI 4 KB boundary rule. Sits between the channel arbiter/command queue and the AR-channel driver.

Parameters:
- ADDR_WD, 32: address width in bits.
- DATA_WD, 32: data width in bits; STRB_WD = DATA_WD/8 is derived as a localparam.
- MAX_BURST_LEN, 16: maximum beats per INCR burst. Power of two, 1..256. FIXED bursts are additionally capped at 16.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_in_valid  in  1  command valid.
- cmd_in_ready  out  1  command ready; high only in IDLE.
- cmd_in_src_addr  in  ADDR_WD  source start address.
- cmd_in_burst  in  axi4_pkg::BURST_BITS  burst type (FIXED or INCR).
- cmd_in_len  in  ADDR_WD  total beats; 0 is legal.
- cmd_in_size  in  axi4_pkg::SIZE_BITS  log2 bytes per beat.
- rd_req_valid  out  1  read request valid.
- rd_req_ready  in  1  read request ready.
- rd_req_addr  out  ADDR_WD  burst start address.
- rd_req_burst  out  axi4_pkg::BURST_BITS  burst type.
- rd_req_len  out  axi4_pkg::LEN_BITS  beats minus 1.
- rd_req_size  out  axi4_pkg::SIZE_BITS  beat size.
- rd_req_last  out  1  last burst of the command.
- cmd_err  out  1  one-cycle pulse on a rejected command.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - state = IDLE.
  - rd_req_valid, rd_req_last, cmd_err, busy = 0.
  - rd_req_* fields = 0.
  - cmd_in_ready = 1, since it is decoded from IDLE. Sources must keep cmd_in_valid low while rst is high.
- FSM states:
  - IDLE: cmd_in_ready = 1. On valid && ready, latch addr, remaining = len, burst and size, then go to CALC.
  - CALC: one cycle. Evaluated in this order:
    - Error check. Any of the following registers cmd_err = 1 for the next cycle and returns to IDLE with no requests issued:
      - burst is WRAP or reserved;
      - size > log2(STRB_WD);
      - addr not aligned to 1<<size.
    - remaining == 0: return to IDLE; no request, no error.
    - Otherwise compute beats, register the rd_req_* fields, go to ISSUE.
  - ISSUE: rd_req_valid = 1. All rd_req_* fields are held stable until rd_req_ready.
    - On handshake: remaining -= beats.
    - Address update: INCR uses addr += beats<<size, modulo 2^ADDR_WD. FIXED leaves addr unchanged.
    - Next state: IDLE if remaining becomes 0, else CALC.
- Beat computation:
  - INCR: beats = min(remaining, MAX_BURST_LEN, (4096 - addr[11:0]) >> size).
  - FIXED: beats = min(remaining, MAX_BURST_LEN, 16).
  - Outputs: rd_req_len = beats-1. rd_req_last = (beats == remaining).
  - Comparisons are done at ADDR_WD width, so remaining > 2^LEN_BITS never truncates.
- Latency:
  - Command handshake at edge N; first rd_req_valid in cycle N+2.
  - After each rd_req handshake, the next rd_req_valid follows 2 cycles later (one CALC bubble).
  - cmd_in_ready returns 1 the cycle after the final handshake.
  - For error and len==0 commands, cmd_in_ready returns 1 in cycle N+2; the cmd_err pulse is also in N+2.
- rd_req_valid never depends combinationally on rd_req_ready.
- A reset asserted mid-command drops the command immediately; all outputs take their reset values asynchronously.

Decomposition:
- axi4_pkg (shared), holds:
  - BURST_BITS, LEN_BITS, SIZE_BITS;
  - the burst_t enum (FIXED/INCR/WRAP);
  - BOUNDARY_4K = 4096.
- dmac_pkg holds the FSM state enum, shared with the write-side generator.
- One natural sub-module: dmac_burst_len_calc. It is purely combinational and maps (addr, remaining, burst, size) to beats. The write generator reuses it.

Test Plan:
1. INCR, addr 0x1000, len 40, size 2 -> three requests:
   - (0x1000, len 15);
   - (0x1040, len 15);
   - (0x1080, len 7, last=1).
   rd_req_valid first seen 2 cycles after command accept.
2. 4K crossing: INCR, addr 0x0FF0, len 16, size 2 -> two requests:
   - (0x0FF0, len 3, last=0);
   - (0x1000, len 11, last=1).
3. FIXED, addr 0x2000, len 20, size 2, MAX_BURST_LEN 32 -> two requests:
   - (0x2000, len 15);
   - (0x2000, len 3, last=1).
4. Backpressure: hold rd_req_ready low for 5 cycles mid-command.
   - rd_req_addr, rd_req_len and rd_req_last stay stable.
   - cmd_in_ready = 0 and busy = 1 throughout.
   - Progress resumes when ready rises.
5. Rejects and empty command:
   - WRAP burst, or addr 0x1002 with size 2 -> cmd_err pulses exactly one cycle; rd_req_valid never asserts.
   - len 0 -> no request and no cmd_err; cmd_in_ready high again 2 cycles after accept.
6. Reset during ISSUE of the second burst of case 1:
   - rd_req_valid falls asynchronously.
   - After release, a new command (addr 0x3000, len 4) yields a single request (0x3000, len 3, last=1).

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 field widths, burst encodings and protocol constants.
package axi4_pkg;

  localparam int BURST_BITS  = 2;
  localparam int LEN_BITS    = 8;
  localparam int SIZE_BITS   = 3;
  localparam int BOUNDARY_4K = 4096;

  typedef enum logic [BURST_BITS-1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

endpackage

// File: rtl/dmac_pkg.sv
// DMA controller shared types: request generator state machine encoding.
package dmac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    ISSUE = 2'b10
  } req_gen_state_t;

endpackage

// File: rtl/dmac_burst_len_calc.sv
// Combinational beat count for the next burst of a DMA command. Honours
// the burst length cap and never lets an INCR burst cross a 4 KB page.
module dmac_burst_len_calc
  import axi4_pkg::*;
#(
  parameter int ADDR_WD       = 32,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [11:0]           page_offset,
  input  logic [ADDR_WD-1:0]    remaining,
  input  logic [BURST_BITS-1:0] burst,
  input  logic [SIZE_BITS-1:0]  size,
  output logic [ADDR_WD-1:0]    beats
);

  localparam int FIXED_CAP = (MAX_BURST_LEN < 16) ? MAX_BURST_LEN : 16;

  logic [ADDR_WD-1:0] page_room;
  logic [ADDR_WD-1:0] cap;

  // Take the smallest of remaining beats, the length cap and the beats left in the page.
  always_comb begin
    page_room = (ADDR_WD'(BOUNDARY_4K) - ADDR_WD'(page_offset)) >> size;
    cap       = (burst == FIXED) ? ADDR_WD'(FIXED_CAP) : ADDR_WD'(MAX_BURST_LEN);
    if ((burst == INCR) && (page_room < cap)) begin
      cap = page_room;
    end
    beats = (remaining < cap) ? remaining : cap;
  end

endmodule

// File: rtl/dmac_read_req_gen.sv
// DMA read request generator: splits one transfer command into AXI4
// read-address requests, one CALC cycle between consecutive requests.
module dmac_read_req_gen
  import axi4_pkg::*;
  import dmac_pkg::*;
#(
  parameter int ADDR_WD       = 32,
  parameter int DATA_WD       = 32,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_in_valid,
  output logic                  cmd_in_ready,
  input  logic [ADDR_WD-1:0]    cmd_in_src_addr,
  input  logic [BURST_BITS-1:0] cmd_in_burst,
  input  logic [ADDR_WD-1:0]    cmd_in_len,
  input  logic [SIZE_BITS-1:0]  cmd_in_size,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_WD-1:0]    rd_req_addr,
  output logic [BURST_BITS-1:0] rd_req_burst,
  output logic [LEN_BITS-1:0]   rd_req_len,
  output logic [SIZE_BITS-1:0]  rd_req_size,
  output logic                  rd_req_last,
  output logic                  cmd_err,
  output logic                  busy
);

  localparam int STRB_WD   = DATA_WD / 8;
  localparam int STRB_LOG2 = $clog2(STRB_WD);

  req_gen_state_t state, state_d;

  logic [ADDR_WD-1:0]    addr_q;
  logic [ADDR_WD-1:0]    remaining_q;
  logic [BURST_BITS-1:0] burst_q;
  logic [SIZE_BITS-1:0]  size_q;
  logic [ADDR_WD-1:0]    beats_q;
  logic [ADDR_WD-1:0]    beats;
  logic [ADDR_WD-1:0]    align_mask;
  logic                  cmd_bad;

  dmac_burst_len_calc #(
    .ADDR_WD       (ADDR_WD),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_len_calc (
    .page_offset (addr_q[11:0]),
    .remaining   (remaining_q),
    .burst       (burst_q),
    .size        (size_q),
    .beats       (beats)
  );

  // Reject commands with an unsupported burst, an oversized beat or a misaligned start.
  always_comb begin
    align_mask = (ADDR_WD'(1) << size_q) - ADDR_WD'(1);
    cmd_bad    = ((burst_q != FIXED) && (burst_q != INCR))
              || (size_q > SIZE_BITS'(STRB_LOG2))
              || ((addr_q & align_mask) != '0);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode: accept, check/compute, then issue until the command is drained.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (cmd_in_valid) begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (cmd_bad || (remaining_q == '0)) begin
          state_d = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rd_req_ready) begin
          state_d = (remaining_q == beats_q) ? IDLE : CALC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, request field registers and progress bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      burst_q      <= '0;
      size_q       <= '0;
      beats_q      <= '0;
      rd_req_addr  <= '0;
      rd_req_burst <= '0;
      rd_req_len   <= '0;
      rd_req_size  <= '0;
      rd_req_last  <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_in_valid) begin
            addr_q      <= cmd_in_src_addr;
            remaining_q <= cmd_in_len;
            burst_q     <= cmd_in_burst;
            size_q      <= cmd_in_size;
          end
        end
        CALC: begin
          if (cmd_bad) begin
            cmd_err <= 1'b1;
          end else if (remaining_q != '0) begin
            beats_q      <= beats;
            rd_req_addr  <= addr_q;
            rd_req_burst <= burst_q;
            rd_req_len   <= LEN_BITS'(beats - ADDR_WD'(1));
            rd_req_size  <= size_q;
            rd_req_last  <= (beats == remaining_q);
          end
        end
        ISSUE: begin
          if (rd_req_ready) begin
            remaining_q <= remaining_q - beats_q;
            if (burst_q == INCR) begin
              addr_q <= addr_q + (beats_q << size_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_in_ready = (state == IDLE);
  assign rd_req_valid = (state == ISSUE);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_dmac_read_req_gen.sv
// Directed bench for dmac_read_req_gen: a table of commands with their
// expected request streams, plus hand-written backpressure and reset sequences.
module tb_dmac_read_req_gen;
  import axi4_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_a, valid_b;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_burst;
  logic [31:0] cmd_len;
  logic [2:0]  cmd_size;
  logic        rd_ready;
  logic        sel_b;

  logic        ready_a, req_valid_a, last_a, err_a, busy_a;
  logic [31:0] addr_a;
  logic [1:0]  burst_a;
  logic [7:0]  len_a;
  logic [2:0]  size_a;
  logic        ready_b, req_valid_b, last_b, err_b, busy_b;
  logic [31:0] addr_b;
  logic [1:0]  burst_b;
  logic [7:0]  len_b;
  logic [2:0]  size_b;

  logic        o_ready, o_valid, o_last, o_err, o_busy;
  logic [31:0] o_addr;
  logic [1:0]  o_burst;
  logic [7:0]  o_len;
  logic [2:0]  o_size;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmac_read_req_gen #(.ADDR_WD(32), .DATA_WD(32), .MAX_BURST_LEN(16)) dut_a (
    .clk(clk), .rst(rst),
    .cmd_in_valid(valid_a), .cmd_in_ready(ready_a),
    .cmd_in_src_addr(cmd_addr), .cmd_in_burst(cmd_burst),
    .cmd_in_len(cmd_len), .cmd_in_size(cmd_size),
    .rd_req_valid(req_valid_a), .rd_req_ready(rd_ready),
    .rd_req_addr(addr_a), .rd_req_burst(burst_a), .rd_req_len(len_a),
    .rd_req_size(size_a), .rd_req_last(last_a),
    .cmd_err(err_a), .busy(busy_a)
  );

  dmac_read_req_gen #(.ADDR_WD(32), .DATA_WD(32), .MAX_BURST_LEN(32)) dut_b (
    .clk(clk), .rst(rst),
    .cmd_in_valid(valid_b), .cmd_in_ready(ready_b),
    .cmd_in_src_addr(cmd_addr), .cmd_in_burst(cmd_burst),
    .cmd_in_len(cmd_len), .cmd_in_size(cmd_size),
    .rd_req_valid(req_valid_b), .rd_req_ready(rd_ready),
    .rd_req_addr(addr_b), .rd_req_burst(burst_b), .rd_req_len(len_b),
    .rd_req_size(size_b), .rd_req_last(last_b),
    .cmd_err(err_b), .busy(busy_b)
  );

  assign o_ready = sel_b ? ready_b     : ready_a;
  assign o_valid = sel_b ? req_valid_b : req_valid_a;
  assign o_last  = sel_b ? last_b      : last_a;
  assign o_err   = sel_b ? err_b       : err_a;
  assign o_busy  = sel_b ? busy_b      : busy_a;
  assign o_addr  = sel_b ? addr_b      : addr_a;
  assign o_burst = sel_b ? burst_b     : burst_a;
  assign o_len   = sel_b ? len_b       : len_a;
  assign o_size  = sel_b ? size_b      : size_a;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [31:0] len;
    logic [2:0]  size;
    bit          on_b;
    bit          exp_err;
    int          first_req;
    int          n_req;
  } cmd_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        last;
  } req_vec_t;

  cmd_vec_t cmds[9];
  req_vec_t reqs[16];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkReq(input req_vec_t r, input logic [1:0] burst, input logic [2:0] size);
    checkOutput("req_valid", 32'(o_valid), 32'd1);
    checkOutput("req_addr", o_addr, r.addr);
    checkOutput("req_len", 32'(o_len), 32'(r.len));
    checkOutput("req_last", 32'(o_last), 32'(r.last));
    checkOutput("req_burst", 32'(o_burst), 32'(burst));
    checkOutput("req_size", 32'(o_size), 32'(size));
    checkOutput("req_no_err", 32'(o_err), 32'd0);
  endtask

  // Present one command, then walk its expected response cycle by cycle.
  task automatic applyStimulus(input cmd_vec_t v);
    @(posedge clk); #1;
    cmd_addr  = v.addr;
    cmd_burst = v.burst;
    cmd_len   = v.len;
    cmd_size  = v.size;
    sel_b     = v.on_b;
    if (v.on_b) valid_b = 1'b1;
    else        valid_a = 1'b1;
    @(negedge clk);
    checkOutput("cmd_ready_idle", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    @(negedge clk);
    checkOutput("calc_valid", 32'(o_valid), 32'd0);
    checkOutput("calc_busy", 32'(o_busy), 32'd1);
    checkOutput("calc_ready", 32'(o_ready), 32'd0);
    if (v.exp_err || (v.n_req == 0)) begin
      @(negedge clk);
      checkOutput("err_pulse", 32'(o_err), 32'(v.exp_err));
      checkOutput("done_ready", 32'(o_ready), 32'd1);
      checkOutput("done_no_valid", 32'(o_valid), 32'd0);
      @(negedge clk);
      checkOutput("err_clear", 32'(o_err), 32'd0);
      checkOutput("after_no_valid", 32'(o_valid), 32'd0);
    end else begin
      for (int k = 0; k < v.n_req; k++) begin
        @(negedge clk);
        checkReq(reqs[v.first_req + k], v.burst, v.size);
        @(negedge clk);
        if (k < v.n_req - 1) begin
          checkOutput("bubble_valid", 32'(o_valid), 32'd0);
        end else begin
          checkOutput("end_ready", 32'(o_ready), 32'd1);
          checkOutput("end_busy", 32'(o_busy), 32'd0);
        end
      end
    end
  endtask

  initial begin
    cmd_vec_t v;
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; rd_ready = 1'b1; sel_b = 1'b0;
    cmd_addr = '0; cmd_burst = '0; cmd_len = '0; cmd_size = '0;

    cmds[0] = '{32'h1000, INCR,  32'd40, 3'd2, 1'b0, 1'b0, 0,  3};
    cmds[1] = '{32'h0FF0, INCR,  32'd16, 3'd2, 1'b0, 1'b0, 3,  2};
    cmds[2] = '{32'h2000, FIXED, 32'd20, 3'd2, 1'b1, 1'b0, 5,  2};
    cmds[3] = '{32'h1000, WRAP,  32'd8,  3'd2, 1'b0, 1'b1, 0,  0};
    cmds[4] = '{32'h1002, INCR,  32'd8,  3'd2, 1'b0, 1'b1, 0,  0};
    cmds[5] = '{32'h1000, INCR,  32'd0,  3'd2, 1'b0, 1'b0, 0,  0};
    cmds[6] = '{32'h0FFE, INCR,  32'd5,  3'd0, 1'b0, 1'b0, 7,  2};
    cmds[7] = '{32'h1000, INCR,  32'd8,  3'd3, 1'b0, 1'b1, 0,  0};
    cmds[8] = '{32'h1000, INCR,  32'd40, 3'd2, 1'b1, 1'b0, 9,  2};
    reqs[0]  = '{32'h1000, 8'd15, 1'b0};
    reqs[1]  = '{32'h1040, 8'd15, 1'b0};
    reqs[2]  = '{32'h1080, 8'd7,  1'b1};
    reqs[3]  = '{32'h0FF0, 8'd3,  1'b0};
    reqs[4]  = '{32'h1000, 8'd11, 1'b1};
    reqs[5]  = '{32'h2000, 8'd15, 1'b0};
    reqs[6]  = '{32'h2000, 8'd3,  1'b1};
    reqs[7]  = '{32'h0FFE, 8'd1,  1'b0};
    reqs[8]  = '{32'h1000, 8'd2,  1'b1};
    reqs[9]  = '{32'h1000, 8'd31, 1'b0};
    reqs[10] = '{32'h1080, 8'd7,  1'b1};
    reqs[11] = '{32'h3000, 8'd3,  1'b1};

    #12;
    checkOutput("rst_valid", 32'(req_valid_a), 32'd0);
    checkOutput("rst_ready", 32'(ready_a), 32'd1);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_err", 32'(err_a), 32'd0);
    checkOutput("rst_addr", addr_a, 32'd0);
    checkOutput("rst_len", 32'(len_a), 32'd0);
    checkOutput("rst_last", 32'(last_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(cmds[i]);
    end

    // Backpressure on the second burst of a three-burst command.
    $display("[TB] backpressure sequence");
    sel_b = 1'b0;
    @(posedge clk); #1;
    cmd_addr = 32'h1000; cmd_burst = INCR; cmd_len = 32'd40; cmd_size = 3'd2; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkReq(reqs[0], INCR, 3'd2);
    @(negedge clk);
    checkOutput("bp_bubble", 32'(o_valid), 32'd0);
    rd_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkReq(reqs[1], INCR, 3'd2);
      checkOutput("bp_ready", 32'(o_ready), 32'd0);
      checkOutput("bp_busy", 32'(o_busy), 32'd1);
    end
    rd_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_resume_bubble", 32'(o_valid), 32'd0);
    @(negedge clk);
    checkReq(reqs[2], INCR, 3'd2);
    @(negedge clk);
    checkOutput("bp_end_ready", 32'(o_ready), 32'd1);

    // Reset while the second burst is being offered.
    $display("[TB] reset sequence");
    @(posedge clk); #1;
    cmd_addr = 32'h1000; cmd_burst = INCR; cmd_len = 32'd40; cmd_size = 3'd2; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkReq(reqs[0], INCR, 3'd2);
    @(negedge clk);
    @(negedge clk);
    checkReq(reqs[1], INCR, 3'd2);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(req_valid_a), 32'd0);
    checkOutput("async_rst_busy", 32'(busy_a), 32'd0);
    checkOutput("async_rst_ready", 32'(ready_a), 32'd1);
    checkOutput("async_rst_addr", addr_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    v = '{32'h3000, INCR, 32'd4, 3'd2, 1'b0, 1'b0, 11, 1};
    applyStimulus(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
